rsa_job_arbiter: RTL and testbench

- Shares one RSA modular-exponentiation engine (result = c^e mod n, the existing 2048-bit top) among NREQ independent requesters.
- Arbitrates round-robin and loads the winner's operands into engine-facing holding registers.
- Sequences the engine's reset/enable/finish protocol, then returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between the host-side job queues and the single engine instance.

---
 rtl/rsa_job_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_rsa_job_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_arbiter.sv
// Round-robin front end that shares one modular-exponentiation engine among NREQ requesters.
// Optional watchdog in RUN is compiled in with `define RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter #(
  parameter int unsigned W    = 2048,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
`ifdef RSA_ARB_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
`endif
) (
  input  logic            clk_i,
  input  logic            sys_rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  input  logic [W-1:0]    op_c_i,
  input  logic [W-1:0]    op_e_i,
  input  logic [W-1:0]    op_n_i,
  output logic [W-1:0]    eng_c_o,
  output logic [W-1:0]    eng_e_o,
  output logic [W-1:0]    eng_n_o,
  output logic            eng_rst_o,
  output logic            eng_enable_o,
  input  logic [W-1:0]    eng_result_i,
  input  logic            eng_finish_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [IDW-1:0]  rsp_id_o,
  output logic [W-1:0]    rsp_result_o,
  output logic            rsp_err_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StEngRst, StRun, StResp} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [W-1:0]    eng_c_q, eng_c_d;
  logic [W-1:0]    eng_e_q, eng_e_d;
  logic [W-1:0]    eng_n_q, eng_n_d;
  logic [W-1:0]    rsp_result_q, rsp_result_d;
  logic            eng_rst_q, eng_rst_d;
  logic            eng_enable_q, eng_enable_d;
  logic            rsp_valid_q, rsp_valid_d;
`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0]     cnt_q, cnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  pick;
  logic            pick_vld;

  // Walk the requesters starting at the round-robin pointer, wrapping at NREQ-1.
  always_comb begin
    cand     = rr_q;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    win_d        = win_q;
    rsp_id_d     = rsp_id_q;
    eng_c_d      = eng_c_q;
    eng_e_d      = eng_e_q;
    eng_n_d      = eng_n_q;
    rsp_result_d = rsp_result_q;
    eng_rst_d    = eng_rst_q;
    eng_enable_d = eng_enable_q;
    rsp_valid_d  = rsp_valid_q;
`ifdef RSA_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        eng_rst_d = 1'b0;
        if (pick_vld) begin
          gnt_d   = NREQ'(1) << pick;
          win_d   = pick;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // op_* are muxed by the winner on the gnt cycle, so latch them now.
        eng_c_d      = op_c_i;
        eng_e_d      = op_e_i;
        eng_n_d      = op_n_i;
        rsp_id_d     = win_q;
        rr_d         = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + IDW'(1);
        gnt_d        = '0;
        eng_rst_d    = 1'b1;
        eng_enable_d = 1'b0;
        state_d      = StEngRst;
      end
      StEngRst: begin
        eng_rst_d    = 1'b0;
        eng_enable_d = 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
        cnt_d        = '0;
`endif
        state_d      = StRun;
      end
      StRun: begin
        if (eng_finish_i) begin
          rsp_result_d = eng_result_i;
          eng_enable_d = 1'b0;
          rsp_valid_d  = 1'b1;
`ifdef RSA_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b0;
`endif
          state_d      = StResp;
        end
`ifdef RSA_ARB_TIMEOUT_EN
        else if (cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
          // Abort: pulse the engine reset so it stops working on the hung job.
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          eng_enable_d = 1'b0;
          eng_rst_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      StResp: begin
        eng_rst_d = 1'b0;
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      rr_q         <= '0;
      win_q        <= '0;
      rsp_id_q     <= '0;
      eng_c_q      <= '0;
      eng_e_q      <= '0;
      eng_n_q      <= '0;
      rsp_result_q <= '0;
      eng_rst_q    <= 1'b1;
      eng_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      win_q        <= win_d;
      rsp_id_q     <= rsp_id_d;
      eng_c_q      <= eng_c_d;
      eng_e_q      <= eng_e_d;
      eng_n_q      <= eng_n_d;
      rsp_result_q <= rsp_result_d;
      eng_rst_q    <= eng_rst_d;
      eng_enable_q <= eng_enable_d;
      rsp_valid_q  <= rsp_valid_d;
`ifdef RSA_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign eng_c_o      = eng_c_q;
  assign eng_e_o      = eng_e_q;
  assign eng_n_o      = eng_n_q;
  assign eng_rst_o    = eng_rst_q;
  assign eng_enable_o = eng_enable_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign busy_o       = (state_q != StIdle);
`ifdef RSA_ARB_TIMEOUT_EN
  assign rsp_err_o    = rsp_err_q;
`else
  assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: vector table, corner sequences and random jobs vs. a reference model.
module tb_rsa_job_arbiter;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [3:0]    req = '0;
  logic [3:0]    gnt;
  logic [W-1:0]  op_c, op_e, op_n;
  logic [W-1:0]  eng_c, eng_e, eng_n;
  logic          eng_rst, eng_enable;
  logic [W-1:0]  eng_result = '0;
  logic          eng_finish = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_id;
  logic [W-1:0]  rsp_result;
  logic          rsp_err;
  logic          busy;

  logic [W-1:0]  tc [4];
  logic [W-1:0]  te [4];
  logic [W-1:0]  tn [4];
  int            eng_lat = 0;
  bit            eng_hang = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            mptr = 0;

  rsa_job_arbiter #(
    .W(W), .NREQ(4), .IDW(2)
`ifdef RSA_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32'd100)
`endif
  ) dut (
    .clk_i(clk), .sys_rst_i(sys_rst), .req_i(req), .gnt_o(gnt),
    .op_c_i(op_c), .op_e_i(op_e), .op_n_i(op_n),
    .eng_c_o(eng_c), .eng_e_o(eng_e), .eng_n_o(eng_n),
    .eng_rst_o(eng_rst), .eng_enable_o(eng_enable),
    .eng_result_i(eng_result), .eng_finish_i(eng_finish),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Requester-side operand mux driven by the grant.
  always_comb begin
    op_c = '0;
    op_e = '0;
    op_n = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        op_c = tc[i];
        op_e = te[i];
        op_n = tn[i];
      end
    end
  end

  function automatic logic [W-1:0] eng_pow(input logic [W-1:0] c, e, n);
    longint unsigned r;
    if (n == 0) return '0;
    r = 64'(1) % 64'(n);
    for (int i = 0; i < int'(e); i++) r = (r * 64'(c)) % 64'(n);
    return W'(r);
  endfunction

  // Engine stand-in: loads while eng_rst, finishes after a random latency, sticky finish.
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_finish <= 1'b0;
      eng_lat    <= $urandom_range(1, 8);
      eng_result <= eng_pow(eng_c, eng_e, eng_n);
    end else if (eng_enable && !eng_finish && !eng_hang) begin
      if (eng_lat <= 1) eng_finish <= 1'b1;
      else eng_lat <= eng_lat - 1;
    end
  end

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] c, e, n);
    longint unsigned r, b;
    r = 64'(1) % 64'(n);
    b = 64'(c) % 64'(n);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * b) % 64'(n);
      b = (b * b) % 64'(n);
    end
    return W'(r);
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // One full job: the winner drops its request after the grant, other bits stay.
  task automatic run_job(input logic [3:0] r, input int w, input logic [W-1:0] exp_res,
                         input int delay);
    logic [3:0] g;
    logic [W-1:0] held;
    int n;
    g = 4'b0001 << w;
    wait_idle();
    req = r;
    tick();
    chk("gnt", 32'(gnt), 32'(g));
    chk("busy_load", 32'(busy), 32'd1);
    req = r & ~g;
    mptr = (w + 1) % 4;
    tick();
    chk("gnt_single", 32'(gnt), 32'd0);
    chk("eng_rst_pulse", 32'(eng_rst), 32'd1);
    chk("eng_en_off", 32'(eng_enable), 32'd0);
    chk("eng_c", 32'(eng_c), 32'(tc[w]));
    chk("eng_n", 32'(eng_n), 32'(tn[w]));
    tick();
    chk("eng_rst_end", 32'(eng_rst), 32'd0);
    chk("eng_en_on", 32'(eng_enable), 32'd1);
    n = 0;
    while (!rsp_valid && n < 300) begin
      tick();
      n++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(w));
    chk("rsp_result", 32'(rsp_result), 32'(exp_res));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    held = rsp_result;
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_result", 32'(rsp_result), 32'(held));
      chk("hold_no_gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("valid_drop", 32'(rsp_valid), 32'd0);
    chk("gap_no_gnt", 32'(gnt), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0]   req;
    logic [W-1:0] c, e, n;
    int           id;
    logic [W-1:0] res;
    int           delay;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [3:0] p;
    logic [3:0] prev;
    int w, ng, nr, n;
    int order[5] = '{0, 1, 2, 3, 0};

    vecs[0] = '{4'b0100, 16'd3, 16'd5, 16'd7, 2, 16'd5, 0};
    vecs[1] = '{4'b1001, 16'd2, 16'd10, 16'd11, 3, 16'd1, 20};
    vecs[2] = '{4'b1001, 16'd4, 16'd3, 16'd10, 0, 16'd4, 1};
    vecs[3] = '{4'b0110, 16'd5, 16'd2, 16'd13, 1, 16'd12, 2};
    vecs[4] = '{4'b0001, 16'd7, 16'd0, 16'd5, 0, 16'd1, 0};
    vecs[5] = '{4'b1100, 16'd6, 16'd2, 16'd10, 2, 16'd6, 3};
    for (int i = 0; i < 4; i++) begin
      tc[i] = '0;
      te[i] = '0;
      tn[i] = 16'd1;
    end

    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_eng_rst", 32'(eng_rst), 32'd1);
    chk("rst_eng_en", 32'(eng_enable), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_eng_c", 32'(eng_c), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    sys_rst = 1'b0;
    tick();
    chk("idle_eng_rst", 32'(eng_rst), 32'd0);

    // Directed vector table.
    foreach (vecs[k]) begin
      for (int i = 0; i < 4; i++) begin
        tc[i] = (i == vecs[k].id) ? vecs[k].c : vecs[k].c + 16'd1;
        te[i] = (i == vecs[k].id) ? vecs[k].e : vecs[k].e + 16'd1;
        tn[i] = (i == vecs[k].id) ? vecs[k].n : vecs[k].n + 16'd2;
      end
      run_job(vecs[k].req, vecs[k].id, vecs[k].res, vecs[k].delay);
    end

    // Reset in the middle of RUN discards the job and returns the pointer to 0.
    tc[2] = 16'd3; te[2] = 16'd5; tn[2] = 16'd7;
    eng_hang = 1'b1;
    wait_idle();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_run", 32'(eng_enable), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("mid_rst_eng_rst", 32'(eng_rst), 32'd1);
    chk("mid_rst_eng_en", 32'(eng_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_eng_c", 32'(eng_c), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    eng_hang = 1'b0;
    mptr = 0;
    tick();
    chk("post_rst_eng_rst", 32'(eng_rst), 32'd0);

    // All four requesting continuously: strict rotation starting at 0.
    req = 4'hF;
    rsp_ready = 1'b1;
    ng = 0;
    nr = 0;
    prev = '0;
    for (int cyc = 0; cyc < 400 && (ng < 5 || busy); cyc++) begin
      tick();
      if (gnt != 0) begin
        if (ng < 5) chk("rr_gnt", 32'(gnt), 32'(4'b0001 << order[ng]));
        else chk("rr_extra_gnt", 32'(gnt), 32'd0);
        chk("rr_single_cycle", 32'(prev), 32'd0);
        ng++;
        if (ng == 5) req = '0;
      end
      if (rsp_valid && nr < 5) begin
        chk("rr_rsp_id", 32'(rsp_id), 32'(order[nr]));
        nr++;
      end
      prev = gnt;
    end
    chk("rr_grants", 32'(ng), 32'd5);
    chk("rr_rsps", 32'(nr), 32'd5);
    rsp_ready = 1'b0;
    mptr = 1;

`ifdef RSA_ARB_TIMEOUT_EN
    // Hung engine: watchdog aborts the job with rsp_err, next job runs normally.
    eng_hang = 1'b1;
    wait_idle();
    req = 4'b0010;
    tick();
    chk("to_gnt", 32'(gnt), 32'd2);
    req = '0;
    mptr = 2;
    n = 0;
    while (!eng_enable && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (!rsp_valid && n < 1000) begin
      tick();
      n++;
    end
    chk("to_cycles_near_100", {31'd0, (n >= 95 && n <= 105)}, 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_result", 32'(rsp_result), 32'd0);
    chk("to_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    eng_hang = 1'b0;
    tc[3] = 16'd2; te[3] = 16'd10; tn[3] = 16'd11;
    run_job(4'b1000, 3, 16'd1, 0);
`endif

    // Randomized jobs against the reference model.
    p = '0;
    for (int j = 0; j < 30; j++) begin
      p = p | 4'($urandom_range(0, 15));
      if (p == 0) p = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        tc[i] = 16'($urandom);
        te[i] = 16'($urandom);
        tn[i] = 16'($urandom_range(2, 65535));
      end
      w = rr_pick(p, mptr);
      run_job(p, w, ref_modexp(tc[w], te[w], tn[w]), $urandom_range(0, 3));
      p[w] = 1'b0;
    end
    req = '0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench timeout");
  end

endmodule
